spi_slave_core: RTL
===================

SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

Interface
REQ-001 SHALL have parameter WordLen, default 8, bits per SPI word (range 4..32).
REQ-002 SHALL have port clk input 1: system clock; all internal state on its rising edge.
REQ-003 SHALL have port rst input 1: reset, asynchronous and active-high.
REQ-004 SHALL have port SCLK input 1: SPI serial clock from master, asynchronous to clk.
REQ-005 SHALL have port CSn input 1: active-low chip select from master.
REQ-006 SHALL have port MOSI input 1: serial data from master.
REQ-007 SHALL have port MISO output 1: serial data to master; 1'bz whenever synchronized CSn=1.
REQ-008 SHALL have ports CPOL and CPHA, each input 1: SPI mode, static while CSn=1.
REQ-009 SHALL have port BitOrder input 1: 1 = LSB first, 0 = MSB first; static while CSn=1.
REQ-010 SHALL have ports TXData input WordLen and TXLoad input 1: host word and write strobe.
REQ-011 SHALL have port TXReady output 1: TX holding buffer empty.
REQ-012 SHALL have ports RXData output WordLen and RXValid output 1: last complete word, one-clk valid pulse.
REQ-013 SHALL have port Busy output 1: FSM not in IDLE.

Function
REQ-014 SHALL pass SCLK, CSn and MOSI through 2-flop synchronizers, then one edge-detect register; SCLK period >= 8 clk required.
REQ-015 SHALL sample MOSI on the leading SCLK edge when CPHA=0 and on the trailing edge when CPHA=1; leading = rising when CPOL=0, falling when CPOL=1; MISO shifts on the opposite edge.
REQ-016 SHALL implement FSM IDLE -> LOAD on synchronized CSn fall; LOAD -> SHIFT after one clk; SHIFT -> LOAD after WordLen samples; any state -> IDLE on synchronized CSn rise.
REQ-017 SHALL, in LOAD, move the TX buffer into the shift register, set TXReady=1 and clear the bit counter; if the buffer is empty, load all-zeros.
REQ-018 SHALL drive the first MISO bit (TX[0] if BitOrder=1, else TX[WordLen-1]) from LOAD onward, so CPHA=0 masters see it before the first edge.
REQ-019 SHALL, on the WordLen-th sample, copy the assembled word to RXData and pulse RXValid exactly 3 clk after the pin-level SCLK sampling edge.
REQ-020 SHALL accept TXLoad only when TXReady=1, setting TXReady=0 next clk; TXLoad while TXReady=0 is ignored.
REQ-021 SHALL, when TXLoad coincides with LOAD and the buffer is empty, place TXData directly into the shift register and leave TXReady=1.
REQ-022 SHALL, on CSn rise mid-word, discard the partial word, emit no RXValid, keep RXData, keep any buffered TX word.
REQ-023 SHALL ignore SCLK edges while synchronized CSn=1.

Reset
REQ-024 SHALL on rst: FSM=IDLE, shift/RX/TX registers 0, bit counter 0, RXValid=0, Busy=0, TXReady=1, MISO=1'bz.
REQ-025 SHALL, if rst deasserts with CSn=0, wait for a CSn fall before starting a word.

Configuration
REQ-026 SHALL, with SPI_SLAVE_STATUS_EN defined, add Underrun and Overrun (output 1, sticky) and StatusClr (input 1) ports.
REQ-027 SHALL, with SPI_SLAVE_STATUS_EN, set Underrun when LOAD finds the buffer empty with no TXLoad, and Overrun when TXLoad arrives with TXReady=0; both cleared by StatusClr, with set winning over a simultaneous clear.
REQ-028 SHALL, without SPI_SLAVE_STATUS_EN, omit those ports and the related logic entirely; other behaviour is identical.

Structure
REQ-029 SHALL place the FSM state enum (IDLE, LOAD, SHIFT), the SPI mode typedef and the default WordLen constant in shared package spi_pkg.
REQ-030 SHALL implement synchronizer plus edge detect as sub-module spi_sync_edge, instantiated for SCLK and CSn, with a synchronizer only for MOSI.

Verification
REQ-031 SHALL cover mode 0, MSB first, TXData=0x3C, master sends 0xA5 -> RXData=0xA5, one RXValid, MISO bits 0,0,1,1,1,1,0,0.
REQ-032 SHALL cover mode 3, LSB first, TXData=0x81, master sends 0x81 -> RXData=0x81, master receives 0x81.
REQ-033 SHALL cover CSn rise after 3 bits -> no RXValid, MISO=z within 3 clk, next full frame 0x5A received correctly.
REQ-034 SHALL cover two back-to-back words with one TXLoad=0xF0 -> MISO 0xF0 then 0x00; with SPI_SLAVE_STATUS_EN, Underrun=1 until StatusClr.
REQ-035 SHALL cover rst asserted mid-word -> all outputs at reset values in the same clk, MISO=z; after CSn re-fall, word 0x33 received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI slave definitions: FSM state encoding, SPI mode pair and default word length.
package spi_pkg;
  localparam int unsigned DefWordLen = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;
endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer plus one edge-detect register for an asynchronous pin.
// level is the synchronized value; toggle pulses for one clk when level changes.
module spi_sync_edge #(
  parameter logic RstVal = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic toggle
);
  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= RstVal;
      s2 <= RstVal;
      s3 <= RstVal;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level  = s2;
  assign toggle = s2 ^ s3;
endmodule

// File: rtl/spi_slave_core.sv
// SPI slave with a one-word TX holding buffer, all four modes and selectable bit order.
// Optional sticky Underrun/Overrun status is built when SPI_SLAVE_STATUS_EN is defined.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int unsigned WordLen = DefWordLen
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               SCLK,
  input  logic               CSn,
  input  logic               MOSI,
  output logic               MISO,
  input  logic               CPOL,
  input  logic               CPHA,
  input  logic               BitOrder,
  input  logic [WordLen-1:0] TXData,
  input  logic               TXLoad,
  output logic               TXReady,
  output logic [WordLen-1:0] RXData,
  output logic               RXValid,
  output logic               Busy
`ifdef SPI_SLAVE_STATUS_EN
  ,
  output logic               Underrun,
  output logic               Overrun,
  input  logic               StatusClr
`endif
);
  localparam int CntW = $clog2(WordLen + 1);

  spi_state_t         state, state_nxt;
  spi_mode_t          mode;
  logic               cs_lvl, cs_tgl, cs_fall;
  logic               sclk_lvl, sclk_tgl;
  logic [1:0]         mosi_sync;
  logic               lead_edge, trail_edge, sample_edge, shift_edge;
  logic               active, in_load, do_sample, do_shift, last_sample;
  logic [CntW-1:0]    bit_cnt;
  logic [WordLen-1:0] tx_sr, rx_sr, rx_nxt, tx_buf, load_word;
  logic               tx_ready, tx_accept, miso_bit;

  assign mode.cpol = CPOL;
  assign mode.cpha = CPHA;

  // CSn sync resets low so a select already held at reset release is not seen as a fall.
  spi_sync_edge #(.RstVal(1'b0)) u_cs_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (CSn),
    .level (cs_lvl),
    .toggle(cs_tgl)
  );

  spi_sync_edge #(.RstVal(1'b0)) u_sclk_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (SCLK),
    .level (sclk_lvl),
    .toggle(sclk_tgl)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_sync <= 2'b00;
    end else begin
      mosi_sync <= {mosi_sync[0], MOSI};
    end
  end

  assign cs_fall     = cs_tgl & ~cs_lvl;
  assign lead_edge   = sclk_tgl & (sclk_lvl ^ mode.cpol);
  assign trail_edge  = sclk_tgl & ~(sclk_lvl ^ mode.cpol);
  assign sample_edge = mode.cpha ? trail_edge : lead_edge;
  assign shift_edge  = mode.cpha ? lead_edge : trail_edge;

  assign active      = (state == SHIFT) && !cs_lvl;
  assign in_load     = (state == LOAD) && !cs_lvl;
  assign do_sample   = active && sample_edge;
  // The first bit is already on MISO from LOAD, so a shift edge before any sample is skipped.
  assign do_shift    = active && shift_edge && (bit_cnt != '0);
  assign last_sample = do_sample && (bit_cnt == CntW'(WordLen - 1));

  assign tx_accept   = TXLoad && tx_ready && !in_load;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (last_sample) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
    if (cs_lvl) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    load_word = '0;
    if (!tx_ready) begin
      load_word = tx_buf;
    end else if (TXLoad) begin
      load_word = TXData;
    end
  end

  always_comb begin
    rx_nxt = BitOrder ? {mosi_sync[1], rx_sr[WordLen-1:1]}
                      : {rx_sr[WordLen-2:0], mosi_sync[1]};
  end

  always_comb begin
    miso_bit = 1'b0;
    if (state == LOAD) begin
      miso_bit = BitOrder ? load_word[0] : load_word[WordLen-1];
    end else begin
      miso_bit = BitOrder ? tx_sr[0] : tx_sr[WordLen-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sr    <= '0;
      rx_sr    <= '0;
      tx_buf   <= '0;
      tx_ready <= 1'b1;
      RXData   <= '0;
      RXValid  <= 1'b0;
      bit_cnt  <= '0;
    end else begin
      RXValid <= 1'b0;
      if (tx_accept) begin
        tx_buf   <= TXData;
        tx_ready <= 1'b0;
      end
      if (in_load) begin
        tx_sr    <= load_word;
        tx_ready <= 1'b1;
        bit_cnt  <= '0;
      end
      if (do_shift) begin
        tx_sr <= BitOrder ? (tx_sr >> 1) : (tx_sr << 1);
      end
      if (do_sample) begin
        rx_sr <= rx_nxt;
        if (last_sample) begin
          RXData  <= rx_nxt;
          RXValid <= 1'b1;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + CntW'(1);
        end
      end
      if (state == IDLE) begin
        bit_cnt <= '0;
      end
    end
  end

`ifdef SPI_SLAVE_STATUS_EN
  // Set wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Underrun <= 1'b0;
      Overrun  <= 1'b0;
    end else begin
      if (in_load && tx_ready && !TXLoad) begin
        Underrun <= 1'b1;
      end else if (StatusClr) begin
        Underrun <= 1'b0;
      end
      if (TXLoad && !tx_ready) begin
        Overrun <= 1'b1;
      end else if (StatusClr) begin
        Overrun <= 1'b0;
      end
    end
  end
`endif

  assign TXReady = tx_ready;
  assign Busy    = (state != IDLE);
  assign MISO    = ((state != IDLE) && !cs_lvl) ? miso_bit : 1'bz;
endmodule
